// File: rtl/sample_framer_if.sv
// Stream bundle for sample_framer: capture-side sample strobe in, frame stream out.
// drop_count exists only when SAMPLE_FRAMER_DROP_CNT_EN is defined.
interface sample_framer_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         overflow;
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
    logic [15:0]  drop_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, overflow, drop_count
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, overflow, drop_count
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, overflow
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, overflow
    );
`endif
endinterface

// File: rtl/sample_framer.sv
// Assembles capture samples into overlapping FRAME_LEN-sample frames advancing HOP samples.
// Define SAMPLE_FRAMER_DROP_CNT_EN to add the 16-bit saturating drop_count output.
module sample_framer #(
    parameter int N         = 16,
    parameter int FRAME_LEN = 64,
    parameter int HOP       = 32
) (
    input  logic           bclk,
    input  logic           reset,
    sample_framer_if.slave bus,
    output logic           o_dbg_state
);
    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int IW    = $clog2(FRAME_LEN);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    logic [N-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_base;
    logic [IW-1:0] r_rd_idx;
    state_t        r_state;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_overflow;

    logic [PW-1:0] w_fill;
    logic          w_full;
    logic          w_write;
    logic          w_hs;
    logic [AW-1:0] w_rd_addr;

    // Output stream: a beat transfers on the edge where out_valid & out_ready;
    // once raised, out_valid/out_data/out_last hold until that transfer (or reset).
    assign w_fill    = r_wr_ptr - r_rd_base;
    assign w_full    = (w_fill == PW'(DEPTH));
    assign w_write   = bus.in_valid & ~w_full;
    assign w_hs      = r_out_valid & bus.out_ready;
    assign w_rd_addr = AW'(r_rd_base + PW'(r_rd_idx));

    always_ff @(posedge bclk) begin
        if (!reset && w_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_base   <= '0;
            r_rd_idx    <= '0;
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // Capture cannot stall: a sample arriving while full is lost.
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end else if (bus.in_valid) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fill >= PW'(FRAME_LEN)) begin
                        r_state     <= S_STREAM;
                        r_rd_idx    <= '0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (r_out_last) begin
                            r_rd_base   <= r_rd_base + PW'(HOP);
                            r_rd_idx    <= '0;
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_rd_idx   <= r_rd_idx + IW'(1);
                            r_out_last <= (r_rd_idx == IW'(FRAME_LEN - 2));
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SAMPLE_FRAMER_DROP_CNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge bclk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (bus.in_valid && w_full && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign bus.drop_count = r_drop_count;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_mem[w_rd_addr];
    assign bus.out_last  = r_out_last;
    assign bus.overflow  = r_overflow;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: directed frames (FRAME_LEN=8, HOP=4 and HOP=8) with a scoreboard queue
// popped by a negedge monitor that also checks hold-while-stalled behaviour.
module tb_sample_framer;
    localparam int N = 16;

    logic bclk = 1'b0;
    logic reset;
    logic dbg_a;
    logic dbg_b;

    always #5 bclk = ~bclk;

    sample_framer_if #(.N(N)) ifa ();
    sample_framer_if #(.N(N)) ifb ();

    sample_framer #(.N(N), .FRAME_LEN(8), .HOP(4)) dut_a (
        .bclk        (bclk),
        .reset       (reset),
        .bus         (ifa),
        .o_dbg_state (dbg_a)
    );

    sample_framer #(.N(N), .FRAME_LEN(8), .HOP(8)) dut_b (
        .bclk        (bclk),
        .reset       (reset),
        .bus         (ifb),
        .o_dbg_state (dbg_b)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [N:0] exp_qa[$];
    logic [N:0] exp_qb[$];
    logic       hold_pend[2];
    logic [N:0] hold_dl[2];
    bit         tog_a = 1'b0;

    // ---------------- clock/reset helpers and drivers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        #1;
        if (tog_a) ifa.out_ready = ~ifa.out_ready;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input int sel, input int v);
        if (sel == 0) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = N'(v);
        end else begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = N'(v);
        end
        tick();
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    task automatic feed(input int sel, input int lo, input int hi, input int gap);
        for (int v = lo; v <= hi; v++) begin
            send(sel, v);
            repeat (gap) tick();
        end
    endtask

    task automatic push(input int sel, input int v, input logic last);
        if (sel == 0) exp_qa.push_back({last, N'(v)});
        else          exp_qb.push_back({last, N'(v)});
    endtask

    task automatic push_range(input int sel, input int lo, input int hi);
        for (int v = lo; v <= hi; v++) push(sel, v, (v == hi));
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? exp_qa.size() : exp_qb.size();
    endfunction

    task automatic drain(input int sel, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (qsize(sel) == 0) break;
            tick();
        end
        chk(name, qsize(sel), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int sel, input logic v, input logic r, input logic rst,
                       input logic [N-1:0] d, input logic l);
        logic [N:0] e;
        if (hold_pend[sel] === 1'b1) begin
            chk("hold_valid", {31'd0, v}, 32'd1);
            chk("hold_data_last", {15'd0, l, d}, {15'd0, hold_dl[sel]});
        end
        if (!rst && v && r) begin
            if (qsize(sel) == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat dut%0d: actual data=%0d last=%0b required=no beat at %0t",
                         sel, d, l, $time);
            end else begin
                if (sel == 0) e = exp_qa.pop_front();
                else          e = exp_qb.pop_front();
                chk("out_data", {16'd0, d}, {16'd0, e[N-1:0]});
                chk("out_last", {31'd0, l}, {31'd0, e[N]});
            end
        end
        hold_pend[sel] = !rst && v && !r;
        hold_dl[sel]   = {l, d};
    endtask

    always @(negedge bclk) begin
        mon(0, ifa.out_valid, ifa.out_ready, reset, ifa.out_data, ifa.out_last);
        mon(1, ifb.out_valid, ifb.out_ready, reset, ifb.out_data, ifb.out_last);
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int cnt;
        reset         = 1'b1;
        hold_pend[0]  = 1'b0;
        hold_pend[1]  = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;
        ifa.out_ready = 1'b0;
        ifb.in_valid  = 1'b0;
        ifb.in_data   = '0;
        ifb.out_ready = 1'b0;
        tick();
        tick();
        tick();
        @(negedge bclk);
        chk("rst_valid_a", {31'd0, ifa.out_valid}, 32'd0);
        chk("rst_last_a", {31'd0, ifa.out_last}, 32'd0);
        chk("rst_ovf_a", {31'd0, ifa.overflow}, 32'd0);
        chk("rst_valid_b", {31'd0, ifb.out_valid}, 32'd0);
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
        chk("rst_drop_a", {16'd0, ifa.drop_count}, 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Test 1: continuous ready, sparse samples, latency check on sample 8
        ifa.out_ready = 1'b1;
        push_range(0, 1, 8);
        push_range(0, 5, 12);
        for (int v = 1; v <= 12; v++) begin
            send(0, v);
            if (v == 8) begin
                @(negedge bclk);
                chk("lat_edge_e", {31'd0, ifa.out_valid}, 32'd0);
                tick();
                @(negedge bclk);
                chk("lat_edge_e1", {31'd0, ifa.out_valid}, 32'd1);
                repeat (18) tick();
            end else begin
                repeat (20) tick();
            end
        end
        drain(0, 50, "t1_drain");

        // Test 2: ready toggling every cycle
        do_reset();
        ifa.out_ready = 1'b1;
        tog_a = 1'b1;
        push_range(0, 1, 8);
        push_range(0, 5, 12);
        feed(0, 1, 12, 20);
        drain(0, 60, "t2_drain");
        tog_a = 1'b0;
        ifa.out_ready = 1'b0;

        // Test 3: stalled consumer, overflow on sample 17, then release
        do_reset();
        feed(0, 1, 16, 2);
        @(negedge bclk);
        chk("t3_no_ovf_at_16", {31'd0, ifa.overflow}, 32'd0);
        send(0, 17);
        @(negedge bclk);
        chk("t3_ovf", {31'd0, ifa.overflow}, 32'd1);
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
        chk("t3_drop_cnt", {16'd0, ifa.drop_count}, 32'd1);
`endif
        push_range(0, 1, 8);
        push_range(0, 5, 12);
        push_range(0, 9, 16);
        ifa.out_ready = 1'b1;
        drain(0, 100, "t3_drain");
        cnt = 0;
        repeat (20) begin
            tick();
            @(negedge bclk);
            if (ifa.out_valid) cnt++;
        end
        chk("t3_no_extra_frame", cnt, 0);
        for (int v = 13; v <= 16; v++) push(0, v, 1'b0);
        push_range(0, 117, 120);
        feed(0, 117, 120, 2);
        drain(0, 40, "t3_tail_drain");
        ifa.out_ready = 1'b0;

        // Test 4: sample 12 lands on the last handshake of frame 1..8
        do_reset();
        feed(0, 1, 11, 1);
        push_range(0, 1, 8);
        push_range(0, 5, 12);
        ifa.out_ready = 1'b1;
        repeat (7) tick();
        send(0, 12);
        @(negedge bclk);
        chk("t4_no_ovf", {31'd0, ifa.overflow}, 32'd0);
        drain(0, 40, "t4_drain");
        ifa.out_ready = 1'b0;

        // Test 4b: buffer full while last handshake happens -> still dropped
        do_reset();
        feed(0, 1, 16, 1);
        push_range(0, 1, 8);
        push_range(0, 5, 12);
        push_range(0, 9, 16);
        ifa.out_ready = 1'b1;
        repeat (7) tick();
        send(0, 17);
        @(negedge bclk);
        chk("t4b_drop_at_last", {31'd0, ifa.overflow}, 32'd1);
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
        chk("t4b_drop_cnt", {16'd0, ifa.drop_count}, 32'd1);
`endif
        drain(0, 60, "t4b_drain");
        ifa.out_ready = 1'b0;

        // Test 5: reset on the third sample of a frame
        do_reset();
        feed(0, 1, 8, 3);
        @(negedge bclk);
        chk("t5_pre_valid", {31'd0, ifa.out_valid}, 32'd1);
        push(0, 1, 1'b0);
        push(0, 2, 1'b0);
        ifa.out_ready = 1'b1;
        tick();
        tick();
        ifa.out_ready = 1'b0;
        reset = 1'b1;
        tick();
        @(negedge bclk);
        chk("t5_valid_after_rst", {31'd0, ifa.out_valid}, 32'd0);
        chk("t5_ovf_after_rst", {31'd0, ifa.overflow}, 32'd0);
        chk("t5_queue_consumed", exp_qa.size(), 0);
        reset = 1'b0;
        tick();
        push_range(0, 101, 108);
        ifa.out_ready = 1'b1;
        feed(0, 101, 108, 2);
        drain(0, 40, "t5_drain");
        ifa.out_ready = 1'b0;

        // Test 6: HOP == FRAME_LEN, non-overlapping frames
        do_reset();
        ifb.out_ready = 1'b1;
        push_range(1, 1, 8);
        push_range(1, 9, 16);
        feed(1, 1, 16, 3);
        drain(1, 40, "t6_drain");
        repeat (5) tick();

        chk("end_qa_empty", exp_qa.size(), 0);
        chk("end_qb_empty", exp_qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
